// File: rtl/md_seq_ctrl_pkg.sv
// md_seq_ctrl_pkg
// Shared multiply/divide definitions (md_defs) for the MIPS pipeline.
// The md_op encodings and default latencies live here so that the
// sequencer, the E-stage decoder and the hazard unit all agree on them.
// No ports: this is a package.
package md_seq_ctrl_pkg;

  // md_op encodings; 3'd7 is unused and behaves like MD_NOP
  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;
  localparam int DEF_CNT_W   = 4;

  // True for the ops that occupy the unit for several cycles
  function automatic logic isLongOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_seq_ctrl_arith.sv
// md_seq_ctrl_arith
// Purely combinational multiply/divide datapath.
// Ports:
//   op       in  3   md_op encoding (only MULT/MULTU/DIV/DIVU produce results)
//   a        in  32  rs operand
//   b        in  32  rt operand
//   result   out 64  {hi, lo}: product, or {remainder, quotient}
//   divZero  out 1   divide op with b == 0; result is then meaningless
module md_seq_ctrl_arith
  import md_seq_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        divZero
);

  logic signed [63:0] w_sProd;
  logic        [63:0] w_uProd;
  logic signed [31:0] w_sA;
  logic signed [31:0] w_sB;
  logic signed [31:0] w_sQuot;
  logic signed [31:0] w_sRem;
  logic        [31:0] w_uQuot;
  logic        [31:0] w_uRem;
  logic               w_bZero;
  logic               w_sOverflow;

  assign w_sA    = a;
  assign w_sB    = b;
  assign w_bZero = (b == 32'd0);

  // Most-negative / -1 overflows a 32-bit quotient; the MIPS result is
  // the dividend back with a zero remainder, handled explicitly so the
  // simulator never evaluates the overflowing division.
  assign w_sOverflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign w_sProd = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_uProd = {32'd0, a} * {32'd0, b};

  // Divisions are guarded so a zero divisor never reaches the operator.
  always_comb begin
    w_sQuot = 32'sd0;
    w_sRem  = 32'sd0;
    w_uQuot = 32'd0;
    w_uRem  = 32'd0;
    if (!w_bZero) begin
      w_uQuot = a / b;
      w_uRem  = a % b;
      if (w_sOverflow) begin
        w_sQuot = w_sA;
        w_sRem  = 32'sd0;
      end else begin
        w_sQuot = w_sA / w_sB;
        w_sRem  = w_sA % w_sB;
      end
    end
  end

  // Select the result for the requested op
  always_comb begin
    result  = 64'd0;
    divZero = 1'b0;
    case (op)
      MD_MULT:  result = w_sProd;
      MD_MULTU: result = w_uProd;
      MD_DIV: begin
        result  = {w_sRem, w_sQuot};
        divZero = w_bZero;
      end
      MD_DIVU: begin
        result  = {w_uRem, w_uQuot};
        divZero = w_bZero;
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl
// Multiply/divide sequencer beside the E-stage ALU. Computes the result
// at issue, holds it in pending registers for a fixed latency, then
// commits it to HI/LO. Also raises the stall that holds F/D while a
// D-stage md-class instruction must wait.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start           E-stage instruction is md-class (qualifies md_op)
//   md_op[2:0]      operation encoding
//   a, b [31:0]     forwarded rs / rt operands
//   md_use_d        D-stage instruction touches the md unit
//   busy            operation in flight
//   stall_md        stall request to the hazard unit
//   done            one-cycle pulse after HI/LO commit
//   hi, lo [31:0]   architectural HI/LO registers
module md_seq_ctrl
  import md_seq_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pendHi;
  logic [31:0]      r_pendLo;
  logic             r_pendZero;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_done;

  logic [63:0]      w_result;
  logic             w_divZero;
  logic             w_longStart;

  md_seq_ctrl_arith u_arith (
    .op      (md_op),
    .a       (a),
    .b       (b),
    .result  (w_result),
    .divZero (w_divZero)
  );

  assign w_longStart = start && isLongOp(md_op);

  assign busy     = (r_cnt != '0);
  assign stall_md = md_use_d && (busy || w_longStart);
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Counter, pending result and HI/LO. While busy every start is ignored;
  // the count-of-one edge is the commit edge. A divide by zero still
  // runs its full latency and pulses done but leaves HI/LO alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_pendHi   <= 32'd0;
      r_pendLo   <= 32'd0;
      r_pendZero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (busy) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          if (!r_pendZero) begin
            r_hi <= r_pendHi;
            r_lo <= r_pendLo;
          end
          r_done <= 1'b1;
        end
      end else if (start) begin
        case (md_op)
          MD_MULT, MD_MULTU: begin
            r_cnt      <= CNT_W'(MUL_LAT);
            r_pendHi   <= w_result[63:32];
            r_pendLo   <= w_result[31:0];
            r_pendZero <= 1'b0;
          end
          MD_DIV, MD_DIVU: begin
            r_cnt      <= CNT_W'(DIV_LAT);
            r_pendHi   <= w_result[63:32];
            r_pendLo   <= w_result[31:0];
            r_pendZero <= w_divZero;
          end
          MD_MTHI: r_hi <= a;
          MD_MTLO: r_lo <= a;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb_md_seq_ctrl
// Self-checking bench for md_seq_ctrl: a table of long operations with
// hand-computed HI/LO and latency, plus directed sequences for stall,
// MTHI/MTLO, ignored starts, NOP and reset during an operation.
module tb_md_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passCount;
  int checkCount;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  md_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_md (stall_md),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and keep the counts
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issue one long op (inputs set just after a falling edge), count busy
  // cycles with a bound, then check latency, done pulse, stall and HI/LO.
  task automatic applyStimulus(input vec_t v, input string name);
    int busyCycles;
    int doneSeen;
    @(negedge clk);
    start = 1'b1; md_op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
    busyCycles = 0;
    doneSeen   = 0;
    while (busy === 1'b1 && busyCycles < 20) begin
      if (done !== 1'b0) doneSeen++;
      if (stall_md !== 1'b0) doneSeen++;
      busyCycles++;
      @(negedge clk);
    end
    checkOutput({name, " latency"}, 32'(busyCycles), 32'(v.lat));
    checkOutput({name, " done/stall while busy"}, 32'(doneSeen), 32'd0);
    checkOutput({name, " done after commit"}, {31'd0, done}, 32'd1);
    checkOutput({name, " hi"}, hi, v.expHi);
    checkOutput({name, " lo"}, lo, v.expLo);
    @(negedge clk);
    checkOutput({name, " done falls"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
    md_use_d = 1'b0;
    passCount = 0; checkCount = 0;

    // op, a, b, expHi, expLo, latency (results in table order; the
    // divide-by-zero row expects the HI/LO left by the row before)
    vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd4, 32'd7,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{3'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 10};
    vecs[6] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[7] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[8] = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[9] = '{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 5};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset stall", {31'd0, stall_md}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);

    // Table-driven long operations
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Stall: MULT with mflo in D; stall in start cycle and all busy cycles.
    // An MTLO presented mid-operation must be ignored.
    @(negedge clk);
    md_use_d = 1'b1; start = 1'b1; md_op = 3'd1; a = 32'd6; b = 32'd7;
    #1 checkOutput("stall start cycle", {31'd0, stall_md}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall busy cyc%0d", c), {30'd0, busy, stall_md}, 32'd3);
      if (c == 1) begin start = 1'b1; md_op = 3'd6; a = 32'hDEAD_BEEF; end
      else begin start = 1'b0; md_op = 3'd0; end
      @(negedge clk);
    end
    checkOutput("stall commit cycle", {30'd0, busy, stall_md}, 32'd0);
    checkOutput("ignored mtlo lo", lo, 32'd42);
    checkOutput("mult 6*7 hi", hi, 32'd0);
    md_use_d = 1'b0;

    // No stall when D does not use the md unit
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; a = 32'd2; b = 32'd2;
    #1 checkOutput("no stall start", {31'd0, stall_md}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && checkCount < 1000) begin
      checkOutput("no stall busy", {31'd0, stall_md}, 32'd0);
      @(negedge clk);
    end
    checkOutput("mult 2*2 lo", lo, 32'd4);

    // MTHI then MTLO in consecutive cycles
    @(negedge clk);
    start = 1'b1; md_op = 3'd5; a = 32'h1234_5678;
    @(negedge clk);
    checkOutput("mthi hi", hi, 32'h1234_5678);
    checkOutput("mthi busy/done", {30'd0, busy, done}, 32'd0);
    md_op = 3'd6; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mtlo lo", lo, 32'h9ABC_DEF0);
    checkOutput("mtlo hi kept", hi, 32'h1234_5678);
    checkOutput("mtlo busy/done", {30'd0, busy, done}, 32'd0);

    // NOP encodings with start have no effect
    start = 1'b1; md_op = 3'd7; a = 32'h5555_5555; b = 32'd3;
    @(negedge clk);
    md_op = 3'd0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("nop hi", hi, 32'h1234_5678);
    checkOutput("nop lo", lo, 32'h9ABC_DEF0);
    checkOutput("nop busy/done", {30'd0, busy, done}, 32'd0);

    // DIV aborted by reset on its 4th busy cycle
    start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("div busy before reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("abort stays cleared", lo, 32'd0);

    // Normal operation after the abort
    applyStimulus('{3'd2, 32'd3, 32'd5, 32'd0, 32'd15, 5}, "post-reset multu");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
